// File: rtl/acc_pkg.sv
// Shared widths and FSM encoding for the accumulator and its inverse (differencer).
package acc_pkg;

  localparam int ACC_W = 16;
  localparam int IN_W  = 8;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ERR  = 2'd2
  } state_t;

endpackage

// File: rtl/acc_diff_calc.sv
// Combinational modular subtract of the reference from the new running sum,
// plus a check that the step fits in an IN_W-bit sample.
module acc_diff_calc
  import acc_pkg::*;
#(
  parameter int ACC_W = acc_pkg::ACC_W,
  parameter int IN_W  = acc_pkg::IN_W
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [ACC_W-1:0] prev,
  output logic [ACC_W-1:0] diff,
  output logic             in_range
);

  // Wrapping subtraction makes an accumulator roll-over look like a small step.
  assign diff     = acc - prev;
  assign in_range = (diff[ACC_W-1:IN_W] == '0);

endmodule

// File: rtl/acc_diff_16bit.sv
// Recovers IN_W-bit samples from a running-sum stream by differencing against the
// last accepted sum; flags (sticky) any step an IN_W-bit sample could not produce.
module acc_diff_16bit
  import acc_pkg::*;
#(
  parameter int ACC_W = acc_pkg::ACC_W,
  parameter int IN_W  = acc_pkg::IN_W,
  parameter int CNT_W = acc_pkg::CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_init,
  input  logic             i_valid,
  input  logic [ACC_W-1:0] i_acc,
  output logic             o_valid,
  output logic [IN_W-1:0]  o_data,
  output logic             o_err,
  output logic [CNT_W-1:0] o_cnt,
  output logic [1:0]       o_state
);

  // Handshake: i_valid qualifies i_acc for exactly the cycle it is high; there is
  // no ready/backpressure. o_valid is a one-cycle strobe qualifying o_data.

  state_t           state, state_n;
  logic [ACC_W-1:0] prev, prev_n;
  logic [ACC_W-1:0] diff;
  logic             in_range;
  logic             valid_n;
  logic [IN_W-1:0]  data_n;
  logic             err_n;
  logic [CNT_W-1:0] cnt_n;

  acc_diff_calc #(
    .ACC_W (ACC_W),
    .IN_W  (IN_W)
  ) u_calc (
    .acc      (i_acc),
    .prev     (prev),
    .diff     (diff),
    .in_range (in_range)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    prev_n  = prev;
    valid_n = 1'b0;
    data_n  = o_data;
    err_n   = o_err;
    cnt_n   = o_cnt;
    if (i_init) begin
      // Init wins over a same-cycle i_valid; that i_acc is dropped.
      state_n = RUN;
      prev_n  = '0;
      cnt_n   = '0;
      err_n   = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (i_valid) begin
            if (in_range) begin
              data_n  = diff[IN_W-1:0];
              valid_n = 1'b1;
              cnt_n   = o_cnt + CNT_W'(1);
              prev_n  = i_acc;
            end else begin
              err_n   = 1'b1;
              state_n = ERR;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prev    <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_err   <= 1'b0;
      o_cnt   <= '0;
    end else begin
      prev    <= prev_n;
      o_valid <= valid_n;
      o_data  <= data_n;
      o_err   <= err_n;
      o_cnt   <= cnt_n;
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_acc_diff_16bit.sv
// Directed bench for acc_diff_16bit: running-sum recovery, wrap, range error,
// init priority and asynchronous reset.
module tb_acc_diff_16bit;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_init;
  logic        i_valid;
  logic [15:0] i_acc;
  logic        o_valid;
  logic [7:0]  o_data;
  logic        o_err;
  logic [7:0]  o_cnt;
  logic [1:0]  o_state;

  int total = 0;
  int bad   = 0;

  acc_diff_16bit dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_init  (i_init),
    .i_valid (i_valid),
    .i_acc   (i_acc),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_err   (o_err),
    .o_cnt   (o_cnt),
    .o_state (o_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic init, input logic valid, input logic [15:0] acc);
    i_init  = init;
    i_valid = valid;
    i_acc   = acc;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic e, input logic [7:0] c, input logic [1:0] s);
    chk({tag, ".valid"}, {31'd0, o_valid}, {31'd0, v});
    chk({tag, ".data"},  {24'd0, o_data},  {24'd0, d});
    chk({tag, ".err"},   {31'd0, o_err},   {31'd0, e});
    chk({tag, ".cnt"},   {24'd0, o_cnt},   {24'd0, c});
    chk({tag, ".state"}, {30'd0, o_state}, {30'd0, s});
  endtask

  initial begin
    logic [15:0] sum;
    i_rst = 1'b1; i_init = 1'b0; i_valid = 1'b0; i_acc = '0;
    #1;
    chk_out("reset", 1'b0, 8'h00, 1'b0, 8'd0, 2'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // i_valid before init is ignored
    cyc(1'b0, 1'b1, 16'h0005);
    chk_out("idle_valid", 1'b0, 8'h00, 1'b0, 8'd0, 2'd0);

    cyc(1'b1, 1'b0, 16'h0000);
    chk_out("init1", 1'b0, 8'h00, 1'b0, 8'd0, 2'd1);

    // running sums of 1..10 recover 1..10
    sum = 0;
    for (int i = 1; i <= 10; i++) begin
      sum = sum + 16'(i);
      cyc(1'b0, 1'b1, sum);
      chk_out("sum_seq", 1'b1, 8'(i), 1'b0, 8'(i), 2'd1);
    end
    cyc(1'b0, 1'b0, 16'h0000);
    chk_out("sum_done", 1'b0, 8'd10, 1'b0, 8'd10, 2'd1);

    // 256 steps of 0xFF (max legal): sum reaches 0xFF00, counter wraps to 0
    cyc(1'b1, 1'b0, 16'h0000);
    sum = 0;
    for (int k = 1; k <= 256; k++) begin
      sum = sum + 16'h00FF;
      cyc(1'b0, 1'b1, sum);
      chk("step_ff.valid", {31'd0, o_valid}, 32'd1);
      chk("step_ff.data", {24'd0, o_data}, 32'hFF);
    end
    chk_out("cnt_wrap", 1'b1, 8'hFF, 1'b0, 8'd0, 2'd1);
    cyc(1'b0, 1'b1, 16'hFFF0);
    chk_out("to_fff0", 1'b1, 8'hF0, 1'b0, 8'd1, 2'd1);
    cyc(1'b0, 1'b1, 16'h0010);
    chk_out("acc_wrap", 1'b1, 8'h20, 1'b0, 8'd2, 2'd1);

    // step of exactly 0x100 from init is out of range
    cyc(1'b1, 1'b0, 16'h0000);
    cyc(1'b0, 1'b1, 16'h0100);
    chk_out("range_err", 1'b0, 8'h20, 1'b1, 8'd0, 2'd2);

    // error after one good sample: data and cnt hold, valid ignored in ERR
    cyc(1'b1, 1'b0, 16'h0000);
    cyc(1'b0, 1'b1, 16'h0003);
    chk_out("pre_err", 1'b1, 8'h03, 1'b0, 8'd1, 2'd1);
    cyc(1'b0, 1'b1, 16'h0103);
    chk_out("err_hold", 1'b0, 8'h03, 1'b1, 8'd1, 2'd2);
    cyc(1'b0, 1'b1, 16'h0004);
    chk_out("err_ignore", 1'b0, 8'h03, 1'b1, 8'd1, 2'd2);
    cyc(1'b1, 1'b0, 16'h0000);
    chk_out("err_clear", 1'b0, 8'h03, 1'b0, 8'd0, 2'd1);

    // zero diff is a valid sample of value 0
    cyc(1'b0, 1'b1, 16'h0000);
    chk_out("zero_diff", 1'b1, 8'h00, 1'b0, 8'd1, 2'd1);

    // init beats valid; i_acc discarded so prev stays 0
    cyc(1'b1, 1'b1, 16'h0042);
    chk_out("init_prio", 1'b0, 8'h00, 1'b0, 8'd0, 2'd1);
    cyc(1'b0, 1'b1, 16'h0007);
    chk_out("after_prio", 1'b1, 8'h07, 1'b0, 8'd1, 2'd1);
    cyc(1'b0, 1'b1, 16'h0009);
    chk_out("pre_rst", 1'b1, 8'h02, 1'b0, 8'd2, 2'd1);

    // asynchronous reset mid-stream, checked before any further clock edge
    i_valid = 1'b0;
    i_rst = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 8'h00, 1'b0, 8'd0, 2'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    cyc(1'b0, 1'b1, 16'h000B);
    chk_out("post_rst", 1'b0, 8'h00, 1'b0, 8'd0, 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
